status_led_array: RTL and testbench
===================================

// Module: status_led_array
// PURPOSE
//  Parametrised N-channel RGB status-LED driver and successor of the 2-channel init indicator.
//  Each channel runs a 4-state health FSM: INIT, READY, LOST or FAULT.
//  The FSM maps to a colour and blink pattern, dimmed by a shared global-brightness PWM.
//  Sits beside the ADC/DAC init controllers and drives the board RGB LEDs.
// PARAMETERS
//  N_CH         2           number of channels (>=1)
//  BRIGHT_W     6           brightness width; PWM period = 2**BRIGHT_W clocks
//  BLINK_TICKS  12500000    clocks per blink tick (8 Hz at 100 MHz); >=2
// PORTS
//  i_clock        in   1           system clock
//  i_nReset       in   1           asynchronous active-low reset
//  i_brightness   in   BRIGHT_W    PWM duty; 0 = dark, 2**BRIGHT_W-1 = max
//  i_init_done    in   N_CH        per-channel init complete (level)
//  i_error        in   N_CH        per-channel error (level)
//  i_clear_fault  in   N_CH        per-channel fault clear (1-clock pulse or level)
//  i_lamp_test    in   1           force all colours on (white) in every channel
//  o_led_r/g/b    out  N_CH        per-channel colour drive, bit ch = channel ch
//  o_state        out  2*N_CH      FSM state; bits [2ch+1:2ch] belong to channel ch
//  o_fault_any    out  1           OR of (state==FAULT) over all channels
// BEHAVIOUR
//  Reset (async, i_nReset=0):
//   - all outputs 0; every FSM in INIT
//   - pwm_cnt, tick_cnt, phase and duty_q all 0
//  PWM:
//   - pwm_cnt wraps 0..2**BRIGHT_W-1
//   - duty_q <= i_brightness only in the clock where pwm_cnt==max (glitch-free)
//   - pwm_on = (pwm_cnt < duty_q)
//   - the first full period after reset is dark
//  Blink timebase:
//   - tick_cnt wraps 0..BLINK_TICKS-1
//   - at terminal count, 3-bit phase increments (wraps 7->0)
//   - slow = phase[2]: on 4 ticks, off 4 ticks (1 Hz)
//   - fast = phase[0]: toggles every tick (4 Hz)
//  FSM encoding: INIT=0, READY=1, LOST=2, FAULT=3. Evaluated every clock, first match wins:
//   1. i_error=1 -> FAULT (from any state, including FAULT)
//   2. FAULT & i_clear_fault=1 -> READY if i_init_done else INIT
//      (error and clear together: error wins, stays FAULT)
//   3. INIT & i_init_done -> READY
//   4. READY & ~i_init_done -> LOST
//   5. LOST & i_init_done -> READY
//   6. otherwise hold
//  FAULT is sticky: only clear (with error low) or reset leaves it.
//  Colour map (registered):
//   - INIT: red & slow
//   - READY: green steady
//   - LOST: blue & slow
//   - FAULT: red & fast
//   - every colour is ANDed with pwm_on
//   - i_lamp_test=1: r=g=b=pwm_on in all channels, FSMs keep running
//  Latency:
//   - input sampled at edge k -> o_state/o_fault_any valid after edge k+1
//   - LED output reflects the new state after edge k+2
//  Channels are independent; shared PWM/blink counters keep all channels phase-aligned.
//  Width rules:
//   - counters are sized with $clog2 and never overflow
//   - phase wrap is intentional modulo-8
//  Reset mid-operation: immediate return to reset values, outputs forced low asynchronously.
// TESTING (bench: N_CH=2, BRIGHT_W=3, BLINK_TICKS=4)
//  1. Reset release, i_brightness=7, inputs 0:
//     - LEDs 0 for the first 8 clocks
//     - then ch0/ch1 red = pwm_on (7/8 duty) gated by phase[2]: on 16 clk, off 16 clk
//  2. Raise i_init_done[0] at edge k:
//     - o_state[1:0]=1 after k+1
//     - o_led_g[0] follows pwm_on from k+2 with no blink; ch1 stays INIT
//  3. Drop i_init_done[0] while READY:
//     - state 2
//     - blue slow-blinks until i_init_done[0]=1, then back to green
//  4. Pulse i_error[1]:
//     - state 3, o_fault_any=1
//     - red toggles every 4 clk
//     - i_clear_fault[1] with i_error[1]=1 holds FAULT
//     - clear with error low -> INIT (init_done low), o_fault_any=0
//  5. Change i_brightness 7->2 mid-period:
//     - duty changes only at the next pwm_cnt wrap
//     - then 2 clocks on / 6 off; brightness 0 gives a constant-dark output
//  6. Assert i_nReset low in FAULT mid-blink:
//     - outputs 0 asynchronously
//     - after release both channels INIT, o_fault_any=0

Source files
------------

// File: rtl/status_led_array.sv
// N-channel RGB status-LED driver: per-channel health FSM mapped to colour/blink,
// dimmed by a shared global-brightness PWM.
module status_led_array #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned BRIGHT_W    = 6,
  parameter int unsigned BLINK_TICKS = 12500000
) (
  input  logic                  i_clock,
  input  logic                  i_nReset,
  input  logic [BRIGHT_W-1:0]   i_brightness,
  input  logic [N_CH-1:0]       i_init_done,
  input  logic [N_CH-1:0]       i_error,
  input  logic [N_CH-1:0]       i_clear_fault,
  input  logic                  i_lamp_test,
  output logic [N_CH-1:0]       o_led_r,
  output logic [N_CH-1:0]       o_led_g,
  output logic [N_CH-1:0]       o_led_b,
  output logic [2*N_CH-1:0]     o_state,
  output logic                  o_fault_any
);

  localparam int unsigned TICK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned PHASE_W = 3;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_LOST  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [BRIGHT_W-1:0] duty_q;
  logic [TICK_W-1:0]   tick_cnt;
  logic [PHASE_W-1:0]  phase;
  logic                pwm_on;
  logic                slow_blink;
  logic                fast_blink;

  state_t              state_q [N_CH];
  state_t              state_d [N_CH];
  logic [N_CH-1:0]     led_r_d;
  logic [N_CH-1:0]     led_g_d;
  logic [N_CH-1:0]     led_b_d;
  logic                fault_any_d;

  // Shared PWM and blink timebase; duty reloads only on PWM wrap to avoid glitches
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      pwm_cnt  <= '0;
      duty_q   <= '0;
      tick_cnt <= '0;
      phase    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
      if (pwm_cnt == {BRIGHT_W{1'b1}}) begin
        duty_q <= i_brightness;
      end
      if (tick_cnt == TICK_MAX) begin
        tick_cnt <= '0;
        phase    <= phase + PHASE_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  assign pwm_on     = (pwm_cnt < duty_q);
  assign slow_blink = phase[2];
  assign fast_blink = phase[0];

  // Per-channel state registers and registered colour drive
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      for (int ch = 0; ch < int'(N_CH); ch++) begin
        state_q[ch] <= ST_INIT;
      end
      o_led_r     <= '0;
      o_led_g     <= '0;
      o_led_b     <= '0;
      o_fault_any <= 1'b0;
    end else begin
      for (int ch = 0; ch < int'(N_CH); ch++) begin
        state_q[ch] <= state_d[ch];
      end
      o_led_r     <= led_r_d;
      o_led_g     <= led_g_d;
      o_led_b     <= led_b_d;
      o_fault_any <= fault_any_d;
    end
  end

  // Next-state (error beats clear) and colour map from the current state
  always_comb begin
    fault_any_d = 1'b0;
    led_r_d     = '0;
    led_g_d     = '0;
    led_b_d     = '0;
    for (int ch = 0; ch < int'(N_CH); ch++) begin
      state_d[ch] = state_q[ch];
      if (i_error[ch]) begin
        state_d[ch] = ST_FAULT;
      end else begin
        unique case (state_q[ch])
          ST_FAULT: if (i_clear_fault[ch]) state_d[ch] = i_init_done[ch] ? ST_READY : ST_INIT;
          ST_INIT:  if (i_init_done[ch])   state_d[ch] = ST_READY;
          ST_READY: if (!i_init_done[ch])  state_d[ch] = ST_LOST;
          ST_LOST:  if (i_init_done[ch])   state_d[ch] = ST_READY;
          default:  state_d[ch] = state_q[ch];
        endcase
      end
      fault_any_d = fault_any_d | (state_d[ch] == ST_FAULT);

      led_r_d[ch] = pwm_on & (i_lamp_test
                              | ((state_q[ch] == ST_INIT)  & slow_blink)
                              | ((state_q[ch] == ST_FAULT) & fast_blink));
      led_g_d[ch] = pwm_on & (i_lamp_test | (state_q[ch] == ST_READY));
      led_b_d[ch] = pwm_on & (i_lamp_test | (state_q[ch] == ST_LOST));
    end
  end

  always_comb begin
    o_state = '0;
    for (int ch = 0; ch < int'(N_CH); ch++) begin
      o_state[2*ch +: 2] = state_q[ch];
    end
  end

endmodule

// File: tb/tb_status_led_array.sv
// Bench for status_led_array: directed scenarios then random traffic, checked every
// cycle against an arithmetic reference model (edge count drives PWM/blink).
module tb_status_led_array;

  localparam int unsigned N_CH        = 2;
  localparam int unsigned BRIGHT_W    = 3;
  localparam int unsigned BLINK_TICKS = 4;
  localparam int PWM_P = 1 << BRIGHT_W;

  logic                i_clock = 1'b0;
  logic                i_nReset = 1'b0;
  logic [BRIGHT_W-1:0] i_brightness = '0;
  logic [N_CH-1:0]     i_init_done = '0;
  logic [N_CH-1:0]     i_error = '0;
  logic [N_CH-1:0]     i_clear_fault = '0;
  logic                i_lamp_test = 1'b0;
  logic [N_CH-1:0]     o_led_r, o_led_g, o_led_b;
  logic [2*N_CH-1:0]   o_state;
  logic                o_fault_any;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: edges since reset, loaded duty, per-channel health code
  int edges;
  int duty;
  int st [N_CH];
  logic [N_CH-1:0] exp_r, exp_g, exp_b;
  logic [2*N_CH-1:0] exp_state;
  logic exp_fault;

  status_led_array #(
    .N_CH(N_CH), .BRIGHT_W(BRIGHT_W), .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .i_clock(i_clock), .i_nReset(i_nReset), .i_brightness(i_brightness),
    .i_init_done(i_init_done), .i_error(i_error), .i_clear_fault(i_clear_fault),
    .i_lamp_test(i_lamp_test), .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b),
    .o_state(o_state), .o_fault_any(o_fault_any)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edges);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(o_state), 32'(exp_state));
    check({tag, ".fault_any"}, 32'(o_fault_any), 32'(exp_fault));
    check({tag, ".r"}, 32'(o_led_r), 32'(exp_r));
    check({tag, ".g"}, 32'(o_led_g), 32'(exp_g));
    check({tag, ".b"}, 32'(o_led_b), 32'(exp_b));
  endtask

  task automatic model_reset();
    edges = 0;
    duty  = 0;
    for (int c = 0; c < int'(N_CH); c++) st[c] = 0;
    exp_r = '0; exp_g = '0; exp_b = '0; exp_state = '0; exp_fault = 1'b0;
  endtask

  // Advance one clock: predict from pre-edge model values and current inputs, then compare
  task automatic step(input string tag);
    int pwm, ph;
    bit on, slow, fast;
    pwm  = edges % PWM_P;
    ph   = (edges / int'(BLINK_TICKS)) % 8;
    on   = pwm < duty;
    slow = ph >= 4;
    fast = (ph % 2) == 1;
    exp_fault = 1'b0;
    for (int c = 0; c < int'(N_CH); c++) begin
      exp_r[c] = on & (i_lamp_test | (st[c] == 0 && slow) | (st[c] == 3 && fast));
      exp_g[c] = on & (i_lamp_test | (st[c] == 1));
      exp_b[c] = on & (i_lamp_test | (st[c] == 2));
      if (i_error[c])                              st[c] = 3;
      else if (st[c] == 3 && i_clear_fault[c])     st[c] = i_init_done[c] ? 1 : 0;
      else if (st[c] == 0 && i_init_done[c])       st[c] = 1;
      else if (st[c] == 1 && !i_init_done[c])      st[c] = 2;
      else if (st[c] == 2 && i_init_done[c])       st[c] = 1;
      exp_state[2*c +: 2] = 2'(st[c]);
      if (st[c] == 3) exp_fault = 1'b1;
    end
    if (pwm == PWM_P - 1) duty = int'(i_brightness);
    edges++;
    @(posedge i_clock);
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    @(negedge i_clock);
    @(negedge i_clock);
    i_brightness = 3'd7;
    i_nReset = 1'b1;

    run("idle_blink", 48);

    i_init_done[0] = 1'b1;
    run("ready", 24);

    i_init_done[0] = 1'b0;
    run("lost", 40);
    i_init_done[0] = 1'b1;
    run("relock", 10);

    i_error[1] = 1'b1;
    step("err_pulse");
    i_error[1] = 1'b0;
    run("fault", 20);
    i_error[1] = 1'b1;
    i_clear_fault[1] = 1'b1;
    step("err_and_clear");
    i_error[1] = 1'b0;
    i_clear_fault[1] = 1'b0;
    run("fault_hold", 5);
    i_clear_fault[1] = 1'b1;
    step("clear");
    i_clear_fault[1] = 1'b0;
    run("after_clear", 10);

    run("align", 3);
    i_brightness = 3'd2;
    run("dim", 32);
    i_brightness = 3'd0;
    run("dark", 24);

    i_brightness = 3'd5;
    i_lamp_test = 1'b1;
    run("lamp", 20);
    i_lamp_test = 1'b0;

    i_error = 2'b11;
    run("fault_both", 14);
    i_nReset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    i_error = '0;
    i_init_done = '0;
    @(negedge i_clock);
    i_nReset = 1'b1;
    run("post_reset", 12);

    i_brightness = 3'd6;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) i_init_done = N_CH'($urandom);
      i_error       = ($urandom_range(0, 31) == 0) ? N_CH'($urandom) : '0;
      i_clear_fault = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
      if ($urandom_range(0, 63) == 0) i_brightness = BRIGHT_W'($urandom);
      if ($urandom_range(0, 31) == 0) i_lamp_test = ~i_lamp_test;
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
